// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer between the I-cache and D-cache sides
// of one single-ported, fixed-latency main memory.
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rd,
    input  logic [AW-1:0] i_addr,
    output logic          i_stall,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_stall,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_busy,
    output logic [15:0]   i_grant_cnt,
    output logic [15:0]   d_grant_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          own_d_q, own_d_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [15:0]   i_cnt_q, i_cnt_d;
    logic [15:0]   d_cnt_q, d_cnt_d;
    logic          d_req_s;
    logic          d_wins_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign d_req_s  = d_rd | d_wr;
    // On a tie the side that did not win last time is served.
    assign d_wins_s = d_req_s & (~i_rd | ~last_d_q);

    // Next-state and next-output computation for the arbiter/sequencer.
    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        own_d_d   = own_d_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        mem_en_d  = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_cnt_d   = i_cnt_q;
        d_cnt_d   = d_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_rd || d_req_s) begin
                    state_d  = S_ISSUE;
                    mem_en_d = 1'b1;
                    own_d_d  = d_wins_s;
                    last_d_d = d_wins_s;
                    if (d_wins_s) begin
                        wr_d    = d_wr;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        d_cnt_d = sat_inc(d_cnt_q);
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = i_addr;
                        i_cnt_d = sat_inc(i_cnt_q);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_busy) begin
                    mem_en_d = 1'b1;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // mem_rdata is valid in this cycle only.
                    state_d  = S_DONE;
                    i_done_d = ~own_d_q;
                    d_done_d = own_d_q;
                    if (!wr_q && own_d_q) begin
                        d_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            last_d_q  <= 1'b0;
            own_d_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 4'd0;
            mem_en_q  <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_cnt_q   <= 16'd0;
            d_cnt_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            own_d_q   <= own_d_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            mem_en_q  <= mem_en_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_cnt_q   <= i_cnt_d;
            d_cnt_q   <= d_cnt_d;
        end
    end

    // Stall follows the request level directly and drops in the done cycle.
    assign i_stall     = rst & i_rd & ~i_done_q;
    assign d_stall     = rst & d_req_s & ~d_done_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_wr      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_grant_cnt = i_cnt_q;
    assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences and a
// randomized run against a timestamp-based transaction model.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd, d_rd, d_wr, mem_busy;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_stall, i_done, d_stall, d_done, mem_en, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt;

    mem_arbiter #(.LATENCY(LAT), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_addr(i_addr), .i_stall(i_stall), .i_done(i_done), .i_rdata(i_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory environment: 16 words, one outstanding read return.
    logic [15:0] mem [16];
    bit          have_ret = 1'b0;
    int          ret_cyc;
    logic [15:0] ret_data;

    typedef struct {
        logic        i_rd, d_rd, d_wr;
        logic [15:0] i_addr, d_addr, d_wdata;
        int          busy;
        logic        exp_d, exp_wr;
        logic [15:0] exp_addr, exp_wdata, exp_rdata;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (have_ret && cyc == ret_cyc) begin
            mem_rdata = ret_data;
            have_ret  = 1'b0;
        end else begin
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (mem_en && !mem_busy && rst) begin
            if (mem_wr) begin
                mem[mem_addr[3:0]] = mem_wdata;
            end else begin
                have_ret = 1'b1;
                ret_cyc  = cyc + LAT;
                ret_data = mem[mem_addr[3:0]];
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_done"}, {i_done, d_done}, 0);
        chk({tag, "_stall"}, {i_stall, d_stall}, 0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
        chk({tag, "_cnt"}, {i_grant_cnt, d_grant_cnt}, 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_busy = 1'b0;
        have_ret = 1'b0;
        settle();
        tick();
        rst = 1'b1;
        settle();
    endtask

    // Model state for the random run.
    bit          m_busy, m_acc, m_own_d, m_wr, m_last_d;
    int          m_grant, m_acc_cyc, m_icnt, m_dcnt;
    logic [15:0] m_addr, m_wdata, m_data, e_irdata, e_drdata;
    bit          i_pend, d_pend, i_block, d_block, e_men, e_idone, e_ddone, win_d;
    int          order [3];
    int          ndone, ni_done;
    bit          got;

    initial begin
        rst = 1'b0;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_busy = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hBEEF;
        mem[5] = 16'h5A5A;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1000, 16'h1234, 3, 1'b1, 1'b1, 16'h1000, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0045, 16'h2000, 16'h0000, 0, 1'b0, 1'b0, 16'h0045, 16'h0000, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0001, 16'h2003, 16'hCAFE, 0, 1'b1, 1'b1, 16'h2003, 16'hCAFE, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 16'h0000, 1, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h1234};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h0007, 16'h0000, 0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hCAFE};

        #3;
        chk_all_zero("reset");
        tick();
        rst = 1'b1;
        settle();

        // Directed vector table.
        foreach (vecs[v]) begin
            int done_off;
            done_off = vecs[v].busy + LAT + 2;
            for (int k = 0; k <= done_off + 1; k++) begin
                tick();
                i_rd     = (k <= done_off) && vecs[v].i_rd;
                d_rd     = (k <= done_off) && vecs[v].d_rd;
                d_wr     = (k <= done_off) && vecs[v].d_wr;
                i_addr   = vecs[v].i_addr;
                d_addr   = vecs[v].d_addr;
                d_wdata  = vecs[v].d_wdata;
                mem_busy = (k >= 1) && (k <= vecs[v].busy);
                settle();
                e_men   = (k >= 1) && (k <= 1 + vecs[v].busy);
                e_idone = (k == done_off) && !vecs[v].exp_d;
                e_ddone = (k == done_off) && vecs[v].exp_d;
                chk("vec_mem_en", mem_en, e_men);
                if (e_men) begin
                    chk("vec_mem_addr", mem_addr, vecs[v].exp_addr);
                    chk("vec_mem_wr", mem_wr, vecs[v].exp_wr);
                    if (vecs[v].exp_wr) chk("vec_mem_wdata", mem_wdata, vecs[v].exp_wdata);
                end
                chk("vec_i_done", i_done, e_idone);
                chk("vec_d_done", d_done, e_ddone);
                chk("vec_i_stall", i_stall, i_rd && !e_idone);
                chk("vec_d_stall", d_stall, (d_rd || d_wr) && !e_ddone);
                if (e_idone) chk("vec_i_rdata", i_rdata, vecs[v].exp_rdata);
                if (e_ddone && !vecs[v].exp_wr) chk("vec_d_rdata", d_rdata, vecs[v].exp_rdata);
            end
        end

        // Reset asserted while a D read sits in WAIT.
        for (int k = 0; k < 3; k++) begin
            tick();
            d_rd = 1'b1; d_wr = 1'b0; d_addr = 16'h0009;
            settle();
        end
        rst = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        d_rd = 1'b0;
        tick();
        settle();
        tick();
        rst = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            tick();
            settle();
            chk("abandon_d_done", d_done, 0);
            chk("abandon_mem_en", mem_en, 0);
        end

        // Both sides held from reset: D, I, D.
        ndone = 0;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            tick();
            i_rd = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
            settle();
            if (i_done || d_done) begin
                order[ndone] = d_done ? 1 : 0;
                ndone++;
            end
        end
        chk("tie_completions", ndone, 3);
        chk("tie_order0_d", order[0], 1);
        chk("tie_order1_i", order[1], 0);
        chk("tie_order2_d", order[2], 1);
        chk("tie_i_cnt", i_grant_cnt, 16'd1);
        chk("tie_d_cnt", d_grant_cnt, 16'd2);
        tick();
        i_rd = 1'b0; d_rd = 1'b0;
        settle();

        // I request withdrawn during WAIT while D is queued.
        ni_done = 0;
        for (int k = 0; k <= 12; k++) begin
            tick();
            i_rd = (k < 2); i_addr = 16'h000A;
            d_rd = (k <= 9); d_wr = 1'b0; d_addr = 16'h000B;
            settle();
            if (i_done) ni_done++;
            if (k == 3) chk("wd_i_stall_dropped", i_stall, 0);
            if (k == 4) chk("wd_i_done", i_done, 1);
            if (k == 5) chk("wd_idle_gap", mem_en, 0);
            if (k == 6) chk("wd_d_issue", {mem_en, mem_addr}, {1'b1, 16'h000B});
            if (k == 9) chk("wd_d_done", d_done, 1);
        end
        chk("wd_i_done_once", ni_done, 1);

        // Grant counter saturation.
        tick();
        force dut.d_cnt_q = 16'hFFFE;
        settle();
        tick();
        release dut.d_cnt_q;
        settle();
        chk("sat_preload", d_grant_cnt, 16'hFFFE);
        for (int n = 0; n < 3; n++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                d_rd = 1'b1;
                settle();
                if (d_done) got = 1'b1;
            end
            chk("sat_done", got, 1);
            tick();
            d_rd = 1'b0;
            settle();
            chk("sat_cnt", d_grant_cnt, 16'hFFFF);
        end

        // Randomized run against the transaction model.
        do_reset();
        m_busy = 0; m_acc = 0; m_last_d = 0; m_icnt = 0; m_dcnt = 0;
        e_irdata = 16'h0; e_drdata = 16'h0;
        i_pend = 0; d_pend = 0; i_block = 0; d_block = 0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (!i_pend && !i_block && $urandom_range(3) == 0) begin
                i_pend = 1'b1;
                i_addr = 16'($urandom);
            end
            if (!d_pend && !d_block && $urandom_range(3) == 0) begin
                d_pend  = 1'b1;
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
                case ($urandom_range(2))
                    0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                    1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                    default: begin d_rd = 1'b1; d_wr = 1'b1; end
                endcase
            end
            i_block = 1'b0;
            d_block = 1'b0;
            i_rd = i_pend;
            if (!d_pend) begin d_rd = 1'b0; d_wr = 1'b0; end
            mem_busy = ($urandom_range(3) == 0);

            e_men   = m_busy && !m_acc && (cyc > m_grant);
            e_idone = m_busy && m_acc && (cyc == m_acc_cyc + LAT + 1) && !m_own_d;
            e_ddone = m_busy && m_acc && (cyc == m_acc_cyc + LAT + 1) && m_own_d;
            if (e_idone && !m_wr) e_irdata = m_data;
            if (e_ddone && !m_wr) e_drdata = m_data;
            settle();

            chk("rnd_mem_en", mem_en, e_men);
            if (e_men) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_wr", mem_wr, m_wr);
                if (m_wr) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_i_done", i_done, e_idone);
            chk("rnd_d_done", d_done, e_ddone);
            chk("rnd_i_stall", i_stall, i_rd && !e_idone);
            chk("rnd_d_stall", d_stall, (d_rd || d_wr) && !e_ddone);
            chk("rnd_i_rdata", i_rdata, e_irdata);
            chk("rnd_d_rdata", d_rdata, e_drdata);

            if (e_men && !mem_busy) begin
                m_acc     = 1'b1;
                m_acc_cyc = cyc;
                m_data    = mem[m_addr[3:0]];
            end
            if (e_idone || e_ddone) begin
                m_busy = 1'b0;
                if (e_idone) begin i_pend = 1'b0; i_block = 1'b1; end
                if (e_ddone) begin d_pend = 1'b0; d_block = 1'b1; end
            end else if (!m_busy && (i_rd || d_rd || d_wr)) begin
                win_d    = (d_rd || d_wr) && (!i_rd || !m_last_d);
                m_last_d = win_d;
                m_own_d  = win_d;
                m_wr     = win_d && d_wr;
                m_addr   = win_d ? d_addr : i_addr;
                m_wdata  = d_wdata;
                m_grant  = cyc;
                m_acc    = 1'b0;
                m_busy   = 1'b1;
                if (win_d) m_dcnt++; else m_icnt++;
            end
        end
        chk("rnd_i_grant_cnt", i_grant_cnt, 16'(m_icnt));
        chk("rnd_d_grant_cnt", d_grant_cnt, 16'(m_dcnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
